packet_arbiter: RTL and testbench
=================================

PACKET_ARBITER -- requirements
Module: packet_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of packet sources sharing the Ethernet Avalon-ST egress.
REQ-002 Parameter DATA_WIDTH, default 64, stream data width in bits.
REQ-003 Parameter GRANT_TIMEOUT, default 64, maximum cycles from grant to the granted source's first valid beat.
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 packet_request  in  2*NUM_REQ  2-bit priority per source at bits [2i+1:2i]; 0 means no request, 3 is highest.
REQ-007 packet_grant  out  NUM_REQ  one-hot grant, registered.
REQ-008 packet_eop  in  NUM_REQ  early end-of-packet per source, pulsed a fixed latency before that source's last beat.
REQ-009 din_valid, din_sop, din_eop, din_error  in  NUM_REQ each  per-source Avalon-ST control.
REQ-010 din_data  in  NUM_REQ*DATA_WIDTH  per-source data, source i at slice i.
REQ-011 din_empty  in  NUM_REQ*3  per-source empty.
REQ-012 dout_ready  in  1  downstream ready; SHALL be forwarded combinationally and unmodified to every source.
REQ-013 dout_valid, dout_sop, dout_eop, dout_error  out  1 each  registered muxed stream.
REQ-014 dout_data  out  DATA_WIDTH  registered muxed data.
REQ-015 dout_empty  out  3  registered muxed empty.
REQ-016 owner  out  2  index of the source currently owning the egress; 0 when idle.
REQ-017 arb_timeout  out  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-018 FSM states SHALL be IDLE, GRANT and DRAIN.
REQ-019 IDLE: with any non-zero request, select the highest priority level; break ties round-robin starting at the index after the last winner. Assert packet_grant for the winner on the next cycle, latch owner, enter GRANT.
REQ-020 IDLE with no request: packet_grant SHALL stay all-zero.
REQ-021 GRANT: packet_grant SHALL stay asserted until packet_eop[owner] is seen, deasserting the following cycle; then enter DRAIN.
REQ-022 DRAIN: hold owner until a beat with din_valid[owner] and din_eop[owner] is accepted; then return to IDLE the following cycle.
REQ-023 Arbitration SHALL take exactly 1 cycle in IDLE; gap from the previous owner's eop beat to the next grant is 2 cycles.
REQ-024 Output mux: in GRANT and DRAIN, the dout_* registers SHALL load owner's din_* one cycle later (latency 1); in IDLE, dout_valid/sop/eop/error SHALL be 0 and dout_data 0.
REQ-025 Beats from non-owner sources SHALL be discarded and never reach dout.
REQ-026 Round-robin pointer SHALL update only when a grant is issued.
REQ-027 Timeout: a counter SHALL start at grant; if no din_valid[owner] occurs within GRANT_TIMEOUT cycles, drop grant, pulse arb_timeout, and return to IDLE without emitting a beat.
REQ-028 If packet_eop[owner] and the eop beat arrive in the same cycle, go directly to IDLE.
REQ-029 Requests changing while in GRANT/DRAIN SHALL have no effect until IDLE.
REQ-030 Requests with value 0 SHALL never win, regardless of round-robin position.

Reset
REQ-031 During rst: state IDLE, packet_grant 0, owner 0, round-robin pointer 0, timeout counter 0, arb_timeout 0, all dout_* 0.
REQ-032 rst asserted mid-packet SHALL abort the transfer; after release the first beat on dout SHALL be a sop.

Verification
REQ-033 Single request: src0 request 3, 5-beat packet -> grant[0] one cycle after request; dout shows 5 beats 1 cycle late, sop on beat 0, eop on beat 4.
REQ-034 Priority: src1 request 1 and src2 request 3 in the same cycle -> grant[2] first, grant[1] after src2's eop beat plus 2 cycles.
REQ-035 Round-robin: all sources request 2 continuously -> grant order 0,1,2,0.
REQ-036 Timeout: src0 granted, never valid -> arb_timeout pulses at grant + GRANT_TIMEOUT; grant drops; no dout beat.
REQ-037 Isolation: src1 drives valid beats while src0 owns the egress -> no src1 data on dout.
REQ-038 Reset at beat 2 of 5 -> outputs 0 next cycle; next packet starts cleanly with sop.

Source files
------------

// File: rtl/packet_arbiter_if.sv
// Signal bundle between the packet sources, the egress arbiter and the downstream sink.
// master = sources/sink side, slave = arbiter side.
interface packet_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 64
);
    logic [2*NUM_REQ-1:0]          packet_request;
    logic [NUM_REQ-1:0]            packet_grant;
    logic [NUM_REQ-1:0]            packet_eop;
    logic [NUM_REQ-1:0]            din_valid;
    logic [NUM_REQ-1:0]            din_sop;
    logic [NUM_REQ-1:0]            din_eop;
    logic [NUM_REQ-1:0]            din_error;
    logic [NUM_REQ*DATA_WIDTH-1:0] din_data;
    logic [NUM_REQ*3-1:0]          din_empty;
    logic [NUM_REQ-1:0]            din_ready;
    logic                          dout_ready;
    logic                          dout_valid;
    logic                          dout_sop;
    logic                          dout_eop;
    logic                          dout_error;
    logic [DATA_WIDTH-1:0]         dout_data;
    logic [2:0]                    dout_empty;
    logic [1:0]                    owner;
    logic                          arb_timeout;

    modport master (
        output packet_request, packet_eop, din_valid, din_sop, din_eop, din_error,
               din_data, din_empty, dout_ready,
        input  packet_grant, din_ready, dout_valid, dout_sop, dout_eop, dout_error,
               dout_data, dout_empty, owner, arb_timeout
    );

    modport slave (
        input  packet_request, packet_eop, din_valid, din_sop, din_eop, din_error,
               din_data, din_empty, dout_ready,
        output packet_grant, din_ready, dout_valid, dout_sop, dout_eop, dout_error,
               dout_data, dout_empty, owner, arb_timeout
    );
endinterface

// File: rtl/packet_arbiter.sv
// Priority + round-robin arbiter that multiplexes NUM_REQ Avalon-ST packet sources
// onto one registered egress stream, with a grant timeout for silent sources.
module packet_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int DATA_WIDTH    = 64,
    parameter int GRANT_TIMEOUT = 64
) (
    input logic             clk,
    input logic             rst,
    packet_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(GRANT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_n;

    logic [NUM_REQ-1:0] grant_q, grant_n;
    logic [IDX_W-1:0]   owner_q, owner_n;
    logic [IDX_W-1:0]   rr_q, rr_n;
    logic [TMR_W-1:0]   timer_q, timer_n;
    logic               got_beat_q, got_beat_n;
    logic               in_pkt_q, in_pkt_n;
    logic               timeout_q, timeout_n;

    logic [1:0]         max_level;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   win_next;
    logic               win_found;
    int                 scan_idx;

    logic                  own_valid;
    logic                  own_sop;
    logic                  own_eop;
    logic                  own_error;
    logic                  own_pkt_eop;
    logic [DATA_WIDTH-1:0] own_data;
    logic [2:0]            own_empty;
    logic                  active;
    logic                  fwd;
    logic                  eop_accept;

    logic                  dout_valid_q;
    logic                  dout_sop_q;
    logic                  dout_eop_q;
    logic                  dout_error_q;
    logic [DATA_WIDTH-1:0] dout_data_q;
    logic [2:0]            dout_empty_q;

    // Highest level wins; among equal levels scan from rr_q upward with wraparound.
    always_comb begin
        max_level = 2'd0;
        win_idx   = '0;
        win_found = 1'b0;
        scan_idx  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.packet_request[2*i +: 2] > max_level) begin
                max_level = bus.packet_request[2*i +: 2];
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!win_found && max_level != 2'd0 &&
                bus.packet_request[2*scan_idx +: 2] == max_level) begin
                win_idx   = scan_idx[IDX_W-1:0];
                win_found = 1'b1;
            end
        end
        win_next = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
    end

    always_comb begin
        own_valid   = 1'b0;
        own_sop     = 1'b0;
        own_eop     = 1'b0;
        own_error   = 1'b0;
        own_pkt_eop = 1'b0;
        own_data    = '0;
        own_empty   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                own_valid   = bus.din_valid[i];
                own_sop     = bus.din_sop[i];
                own_eop     = bus.din_eop[i];
                own_error   = bus.din_error[i];
                own_pkt_eop = bus.packet_eop[i];
                own_data    = bus.din_data[i*DATA_WIDTH +: DATA_WIDTH];
                own_empty   = bus.din_empty[i*3 +: 3];
            end
        end
    end

    // Beats are only forwarded from a sop onward, so a source that was cut off by
    // reset cannot leak the tail of its old packet onto the egress.
    assign active     = (state_q != IDLE);
    assign fwd        = active && own_valid && bus.dout_ready && (own_sop || in_pkt_q);
    assign eop_accept = active && own_valid && bus.dout_ready && own_eop;

    always_comb begin
        state_n    = state_q;
        grant_n    = grant_q;
        owner_n    = owner_q;
        rr_n       = rr_q;
        timer_n    = timer_q;
        got_beat_n = got_beat_q;
        in_pkt_n   = in_pkt_q;
        timeout_n  = 1'b0;

        if (fwd) begin
            in_pkt_n = !own_eop;
        end

        unique case (state_q)
            IDLE: begin
                grant_n    = '0;
                owner_n    = '0;
                timer_n    = '0;
                got_beat_n = 1'b0;
                in_pkt_n   = 1'b0;
                if (win_found) begin
                    grant_n = NUM_REQ'(1) << win_idx;
                    owner_n = win_idx;
                    rr_n    = win_next;
                    state_n = GRANT;
                end
            end
            GRANT, DRAIN: begin
                if (own_valid) begin
                    got_beat_n = 1'b1;
                end else if (!got_beat_q) begin
                    timer_n = timer_q + 1'b1;
                end

                if (!got_beat_q && !own_valid && timer_q == TMR_W'(GRANT_TIMEOUT - 1)) begin
                    state_n   = IDLE;
                    grant_n   = '0;
                    owner_n   = '0;
                    timeout_n = 1'b1;
                end else if (eop_accept && (state_q == DRAIN || own_pkt_eop)) begin
                    state_n = IDLE;
                    grant_n = '0;
                    owner_n = '0;
                end else if (state_q == GRANT && own_pkt_eop) begin
                    state_n = DRAIN;
                    grant_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                owner_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_q       <= '0;
            timer_q    <= '0;
            got_beat_q <= 1'b0;
            in_pkt_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_n;
            grant_q    <= grant_n;
            owner_q    <= owner_n;
            rr_q       <= rr_n;
            timer_q    <= timer_n;
            got_beat_q <= got_beat_n;
            in_pkt_q   <= in_pkt_n;
            timeout_q  <= timeout_n;
        end
    end

    // Egress register stage: one cycle behind the owner's input, forced quiet in IDLE.
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) begin
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            dout_eop_q   <= 1'b0;
            dout_error_q <= 1'b0;
            dout_data_q  <= '0;
            dout_empty_q <= '0;
        end else begin
            dout_valid_q <= fwd;
            dout_sop_q   <= fwd && own_sop;
            dout_eop_q   <= fwd && own_eop;
            dout_error_q <= fwd && own_error;
            dout_data_q  <= own_data;
            dout_empty_q <= own_empty;
        end
    end

    assign bus.din_ready    = {NUM_REQ{bus.dout_ready}};
    assign bus.packet_grant = grant_q;
    assign bus.owner        = 2'(owner_q);
    assign bus.arb_timeout  = timeout_q;
    assign bus.dout_valid   = dout_valid_q;
    assign bus.dout_sop     = dout_sop_q;
    assign bus.dout_eop     = dout_eop_q;
    assign bus.dout_error   = dout_error_q;
    assign bus.dout_data    = dout_data_q;
    assign bus.dout_empty   = dout_empty_q;

    grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    grant_only_when_active: assert property (@(posedge clk) disable iff (rst)
        (grant_q != '0) |-> (state_q == GRANT));
    timeout_is_pulse: assert property (@(posedge clk) disable iff (rst)
        timeout_q |=> !timeout_q);

endmodule

// File: tb/tb_packet_arbiter.sv
// Directed bench for packet_arbiter: reset, single packet, priority, round-robin,
// timeout, source isolation and mid-packet reset.
module tb_packet_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 64;
    localparam int TMO  = 16;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    packet_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW)) bus ();

    packet_arbiter #(
        .NUM_REQ      (NREQ),
        .DATA_WIDTH   (DW),
        .GRANT_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_src();
        bus.din_valid  = '0;
        bus.din_sop    = '0;
        bus.din_eop    = '0;
        bus.din_error  = '0;
        bus.din_data   = '0;
        bus.din_empty  = '0;
        bus.packet_eop = '0;
    endtask

    task automatic drive_beat(input int src, input logic [DW-1:0] data,
                              input logic sop, input logic eop, input logic peop);
        bus.din_valid[src]          = 1'b1;
        bus.din_sop[src]            = sop;
        bus.din_eop[src]            = eop;
        bus.din_error[src]          = 1'b0;
        bus.din_data[src*DW +: DW]  = data;
        bus.packet_eop[src]         = peop;
    endtask

    task automatic pulse_reset();
        bus.packet_request = '0;
        clear_src();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.packet_request = 6'b111111;
        drive_beat(0, 64'h1111, 1'b1, 1'b0, 1'b0);
        step();
        step();
        checks++; if (bus.packet_grant !== 3'b000) begin fails++; $display("[TB] FAIL reset_grant: got %b expected %b", bus.packet_grant, 3'b000); end
        checks++; if (bus.owner !== 2'd0) begin fails++; $display("[TB] FAIL reset_owner: got %0d expected 0", bus.owner); end
        checks++; if (bus.dout_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_dout_valid: got %b expected 0", bus.dout_valid); end
        checks++; if (bus.dout_data !== 64'h0) begin fails++; $display("[TB] FAIL reset_dout_data: got %h expected 0", bus.dout_data); end
        checks++; if (bus.arb_timeout !== 1'b0) begin fails++; $display("[TB] FAIL reset_timeout: got %b expected 0", bus.arb_timeout); end
        bus.dout_ready = 1'b1;
        #1;
        checks++; if (bus.din_ready !== 3'b111) begin fails++; $display("[TB] FAIL ready_fwd_high: got %b expected 111", bus.din_ready); end
        bus.dout_ready = 1'b0;
        #1;
        checks++; if (bus.din_ready !== 3'b000) begin fails++; $display("[TB] FAIL ready_fwd_low: got %b expected 000", bus.din_ready); end
        bus.dout_ready = 1'b1;
        bus.packet_request = '0;
        clear_src();
        rst = 1'b0;
        step();
        checks++; if (bus.packet_grant !== 3'b000) begin fails++; $display("[TB] FAIL idle_no_request_grant: got %b expected 000", bus.packet_grant); end
    endtask

    task automatic test_single();
        logic [2:0] exp_g;
        bus.packet_request = 6'b000011;
        step();
        checks++; if (bus.packet_grant !== 3'b001) begin fails++; $display("[TB] FAIL single_grant: got %b expected 001", bus.packet_grant); end
        bus.packet_request = '0;
        for (int k = 0; k < 5; k++) begin
            clear_src();
            drive_beat(0, 64'hA0 + 64'(k), k == 0, k == 4, k == 2);
            step();
            exp_g = (k >= 2) ? 3'b000 : 3'b001;
            checks++; if (bus.dout_valid !== 1'b1 || bus.dout_data !== 64'hA0 + 64'(k)) begin fails++; $display("[TB] FAIL single_beat%0d: got valid=%b data=%h expected valid=1 data=%h", k, bus.dout_valid, bus.dout_data, 64'hA0 + 64'(k)); end
            checks++; if (bus.dout_sop !== (k == 0) || bus.dout_eop !== (k == 4)) begin fails++; $display("[TB] FAIL single_sopeop%0d: got sop=%b eop=%b expected sop=%b eop=%b", k, bus.dout_sop, bus.dout_eop, k == 0, k == 4); end
            checks++; if (bus.packet_grant !== exp_g) begin fails++; $display("[TB] FAIL single_grant_beat%0d: got %b expected %b", k, bus.packet_grant, exp_g); end
        end
        clear_src();
        step();
        checks++; if (bus.dout_valid !== 1'b0 || bus.dout_data !== 64'h0) begin fails++; $display("[TB] FAIL single_idle_dout: got valid=%b data=%h expected 0/0", bus.dout_valid, bus.dout_data); end
    endtask

    task automatic test_priority();
        bus.packet_request = 6'b110100;
        step();
        checks++; if (bus.packet_grant !== 3'b100 || bus.owner !== 2'd2) begin fails++; $display("[TB] FAIL prio_first: got grant=%b owner=%0d expected 100/2", bus.packet_grant, bus.owner); end
        bus.packet_request = 6'b000100;
        for (int k = 0; k < 3; k++) begin
            clear_src();
            drive_beat(2, 64'h200 + 64'(k), k == 0, k == 2, k == 1);
            step();
            checks++; if (bus.dout_data !== 64'h200 + 64'(k)) begin fails++; $display("[TB] FAIL prio_beat%0d: got %h expected %h", k, bus.dout_data, 64'h200 + 64'(k)); end
        end
        checks++; if (bus.packet_grant !== 3'b000) begin fails++; $display("[TB] FAIL prio_gap: got %b expected 000", bus.packet_grant); end
        clear_src();
        step();
        checks++; if (bus.packet_grant !== 3'b010 || bus.owner !== 2'd1) begin fails++; $display("[TB] FAIL prio_second: got grant=%b owner=%0d expected 010/1", bus.packet_grant, bus.owner); end
        bus.packet_request = '0;
        drive_beat(1, 64'h3AB, 1'b1, 1'b1, 1'b1);
        step();
        checks++; if (bus.dout_valid !== 1'b1 || bus.dout_sop !== 1'b1 || bus.dout_eop !== 1'b1) begin fails++; $display("[TB] FAIL same_cycle_eop_beat: got v/s/e=%b%b%b expected 111", bus.dout_valid, bus.dout_sop, bus.dout_eop); end
        checks++; if (bus.owner !== 2'd0 || bus.packet_grant !== 3'b000) begin fails++; $display("[TB] FAIL same_cycle_eop_idle: got owner=%0d grant=%b expected 0/000", bus.owner, bus.packet_grant); end
        clear_src();
        step();
    endtask

    task automatic test_round_robin();
        int         order [4] = '{0, 1, 2, 0};
        logic [2:0] exp_g;
        pulse_reset();
        bus.packet_request = 6'b101010;
        step();
        for (int n = 0; n < 4; n++) begin
            exp_g = 3'b001 << order[n];
            checks++; if (bus.packet_grant !== exp_g || bus.owner !== 2'(order[n])) begin fails++; $display("[TB] FAIL rr_grant%0d: got grant=%b owner=%0d expected %b/%0d", n, bus.packet_grant, bus.owner, exp_g, order[n]); end
            drive_beat(order[n], 64'h400 + 64'(n), 1'b1, 1'b1, 1'b1);
            step();
            clear_src();
            step();
        end
    endtask

    task automatic test_timeout();
        pulse_reset();
        bus.packet_request = 6'b000011;
        step();
        bus.packet_request = '0;
        for (int i = 1; i < TMO; i++) begin
            step();
            checks++; if (bus.arb_timeout !== 1'b0 || bus.packet_grant !== 3'b001) begin fails++; $display("[TB] FAIL timeout_early%0d: got to=%b grant=%b expected 0/001", i, bus.arb_timeout, bus.packet_grant); end
        end
        step();
        checks++; if (bus.arb_timeout !== 1'b1) begin fails++; $display("[TB] FAIL timeout_pulse: got %b expected 1", bus.arb_timeout); end
        checks++; if (bus.packet_grant !== 3'b000 || bus.dout_valid !== 1'b0) begin fails++; $display("[TB] FAIL timeout_drop: got grant=%b valid=%b expected 000/0", bus.packet_grant, bus.dout_valid); end
        step();
        checks++; if (bus.arb_timeout !== 1'b0) begin fails++; $display("[TB] FAIL timeout_one_cycle: got %b expected 0", bus.arb_timeout); end
    endtask

    task automatic test_isolation();
        logic [2:0] exp_g;
        bus.packet_request = 6'b000011;
        step();
        bus.packet_request = 6'b001100;
        for (int k = 0; k < 3; k++) begin
            clear_src();
            drive_beat(0, 64'h5000 + 64'(k), k == 0, k == 2, k == 1);
            drive_beat(1, 64'hDEADBEEF, 1'b1, 1'b1, 1'b1);
            step();
            exp_g = (k >= 1) ? 3'b000 : 3'b001;
            checks++; if (bus.dout_valid !== 1'b1 || bus.dout_data !== 64'h5000 + 64'(k)) begin fails++; $display("[TB] FAIL isolation_beat%0d: got valid=%b data=%h expected 1/%h", k, bus.dout_valid, bus.dout_data, 64'h5000 + 64'(k)); end
            checks++; if (bus.packet_grant !== exp_g) begin fails++; $display("[TB] FAIL isolation_grant%0d: got %b expected %b", k, bus.packet_grant, exp_g); end
        end
    endtask

    task automatic test_reset_mid_packet();
        pulse_reset();
        bus.packet_request = 6'b000011;
        step();
        bus.packet_request = '0;
        for (int k = 0; k < 2; k++) begin
            clear_src();
            drive_beat(0, 64'h600 + 64'(k), k == 0, 1'b0, 1'b0);
            step();
        end
        checks++; if (bus.dout_valid !== 1'b1 || bus.dout_data !== 64'h601) begin fails++; $display("[TB] FAIL midreset_before: got valid=%b data=%h expected 1/601", bus.dout_valid, bus.dout_data); end
        clear_src();
        drive_beat(0, 64'h602, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        checks++; if (bus.dout_valid !== 1'b0 || bus.dout_data !== 64'h0 || bus.packet_grant !== 3'b000 || bus.owner !== 2'd0) begin fails++; $display("[TB] FAIL midreset_outputs: got valid=%b data=%h grant=%b owner=%0d expected all 0", bus.dout_valid, bus.dout_data, bus.packet_grant, bus.owner); end
        rst = 1'b0;
        clear_src();
        bus.packet_request = 6'b000011;
        step();
        bus.packet_request = '0;
        drive_beat(0, 64'hBAD0, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (bus.dout_valid !== 1'b0) begin fails++; $display("[TB] FAIL midreset_stale_beat: got valid=%b expected 0", bus.dout_valid); end
        clear_src();
        drive_beat(0, 64'hC0, 1'b1, 1'b0, 1'b1);
        step();
        checks++; if (bus.dout_valid !== 1'b1 || bus.dout_sop !== 1'b1 || bus.dout_data !== 64'hC0) begin fails++; $display("[TB] FAIL midreset_sop: got valid=%b sop=%b data=%h expected 1/1/c0", bus.dout_valid, bus.dout_sop, bus.dout_data); end
        clear_src();
        drive_beat(0, 64'hC1, 1'b0, 1'b1, 1'b0);
        step();
        checks++; if (bus.dout_eop !== 1'b1 || bus.dout_data !== 64'hC1) begin fails++; $display("[TB] FAIL midreset_eop: got eop=%b data=%h expected 1/c1", bus.dout_eop, bus.dout_data); end
        clear_src();
        step();
        checks++; if (bus.dout_valid !== 1'b0) begin fails++; $display("[TB] FAIL midreset_idle: got valid=%b expected 0", bus.dout_valid); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        bus.packet_request = '0;
        bus.dout_ready     = 1'b1;
        clear_src();
        test_reset();
        test_single();
        test_priority();
        test_round_robin();
        test_timeout();
        test_isolation();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
